// File: rtl/pipeline_ctrl.sv
// rtl/pipeline_ctrl.sv - pipeline sequencing controller for the 5-stage core
//
// Drives the IF/ID/EX stage-register clock enables and the squash/bubble
// controls around EX. Handles load-use hazards, iterative mul/div occupancy
// of EX, branch/jump redirects from EX and whole-pipe external stalls.
//
// Optional feature macro: PIPE_CTRL_PERF_EN (adds stall/flush counters).
//
// Parameters:
//   MD_TIMEOUT       cycles to wait in MD_WAIT for i_md_done before aborting
//   PERF_W           width of the performance counters (PIPE_CTRL_PERF_EN only)
//
// Ports:
//   clk, rst_n               clock; asynchronous active-low reset
//   i_ext_stall              data memory not ready, freezes the whole pipe
//   i_id_rs1/rs2             source registers of the instruction in ID
//   i_id_uses_rs1/rs2        ID instruction actually reads rs1/rs2
//   i_ex_mem_rd, i_ex_rd     EX instruction is a load / its destination
//   i_ex_flush               taken branch/jump resolved in EX
//   i_ex_muldiv              EX instruction is a multi-cycle mul/div
//   i_md_done                mul/div result valid (single-cycle pulse)
//   o_md_start               mul/div launch pulse
//   o_if_en/id_en/ex_en      stage register clock enables
//   o_if_id_flush            squash IF/ID contents
//   o_id_ex_bubble           load a NOP into ID/EX
//   o_pc_sel                 next PC comes from the EX jump address
//   o_md_timeout             sticky: mul/div never finished
//   o_state                  FSM state (debug)
//   o_perf_stall_cnt         cycles with o_if_en=0 (PIPE_CTRL_PERF_EN only)
//   o_perf_flush_cnt         cycles with o_if_id_flush=1 (PIPE_CTRL_PERF_EN only)

module pipeline_ctrl #(
    parameter int MD_TIMEOUT = 64,
    parameter int PERF_W     = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_ext_stall,
    input  logic [4:0]        i_id_rs1,
    input  logic [4:0]        i_id_rs2,
    input  logic              i_id_uses_rs1,
    input  logic              i_id_uses_rs2,
    input  logic              i_ex_mem_rd,
    input  logic [4:0]        i_ex_rd,
    input  logic              i_ex_flush,
    input  logic              i_ex_muldiv,
    input  logic              i_md_done,
    output logic              o_md_start,
    output logic              o_if_en,
    output logic              o_id_en,
    output logic              o_ex_en,
    output logic              o_if_id_flush,
    output logic              o_id_ex_bubble,
    output logic              o_pc_sel,
    output logic              o_md_timeout,
    output logic [1:0]        o_state
`ifdef PIPE_CTRL_PERF_EN
    ,
    output logic [PERF_W-1:0] o_perf_stall_cnt,
    output logic [PERF_W-1:0] o_perf_flush_cnt
`endif
);

    typedef enum logic [1:0] {
        ST_RUN        = 2'd0,
        ST_LOAD_STALL = 2'd1,
        ST_MD_WAIT    = 2'd2
    } state_t;

    localparam int CNT_W = (MD_TIMEOUT > 2) ? $clog2(MD_TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MD_TIMEOUT - 1);

    state_t             state_q;
    state_t             state_d;
    logic               go_q;       // low during reset and the first cycle after it
    logic               done_q;     // i_md_done seen while still blocked by a stall
    logic [CNT_W-1:0]   cnt_q;
    logic               to_q;
    logic               cnt_clr;
    logic               to_set;
    logic               hz;

    assign hz = i_ex_mem_rd && (i_ex_rd != 5'd0) &&
                ((i_id_uses_rs1 && (i_id_rs1 == i_ex_rd)) ||
                 (i_id_uses_rs2 && (i_id_rs2 == i_ex_rd)));

    assign o_md_timeout = to_q;
    assign o_state      = state_q;

    always_comb begin
        o_md_start     = 1'b0;
        o_if_en        = 1'b0;
        o_id_en        = 1'b0;
        o_ex_en        = 1'b0;
        o_if_id_flush  = 1'b0;
        o_id_ex_bubble = 1'b0;
        o_pc_sel       = 1'b0;
        state_d        = state_q;
        cnt_clr        = 1'b0;
        to_set         = 1'b0;

        // Nothing is driven until the first edge after reset release, so the
        // stage registers see a clean, frozen pipe while reset settles.
        if (go_q) begin
            case (state_q)
                ST_LOAD_STALL: begin
                    if (!i_ext_stall) begin
                        o_if_en = 1'b1;
                        o_id_en = 1'b1;
                        o_ex_en = 1'b1;
                        state_d = ST_RUN;
                    end
                end
                ST_MD_WAIT: begin
                    if ((i_md_done || done_q) && !i_ext_stall) begin
                        o_if_en = 1'b1;
                        o_id_en = 1'b1;
                        o_ex_en = 1'b1;
                        state_d = ST_RUN;
                    end else if (cnt_q == CNT_MAX && !i_md_done && !done_q) begin
                        // Abort: release the pipe even if a stall is pending so
                        // the core cannot deadlock on a dead mul/div unit.
                        o_if_en = 1'b1;
                        o_id_en = 1'b1;
                        o_ex_en = 1'b1;
                        to_set  = 1'b1;
                        state_d = ST_RUN;
                    end
                end
                default: begin
                    // ST_RUN, and the unused encoding which behaves as RUN.
                    if (i_ext_stall) begin
                        state_d = ST_RUN;
                    end else if (i_ex_flush) begin
                        o_if_en        = 1'b1;
                        o_id_en        = 1'b1;
                        o_ex_en        = 1'b1;
                        o_pc_sel       = 1'b1;
                        o_if_id_flush  = 1'b1;
                        o_id_ex_bubble = 1'b1;
                        state_d        = ST_RUN;
                    end else if (i_ex_muldiv) begin
                        o_md_start = 1'b1;
                        cnt_clr    = 1'b1;
                        state_d    = ST_MD_WAIT;
                    end else if (hz) begin
                        o_ex_en        = 1'b1;
                        o_id_ex_bubble = 1'b1;
                        state_d        = ST_LOAD_STALL;
                    end else begin
                        o_if_en = 1'b1;
                        o_id_en = 1'b1;
                        o_ex_en = 1'b1;
                        state_d = ST_RUN;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            go_q    <= 1'b0;
            state_q <= ST_RUN;
            done_q  <= 1'b0;
            cnt_q   <= '0;
            to_q    <= 1'b0;
        end else begin
            go_q    <= 1'b1;
            state_q <= state_d;

            if (state_q == ST_MD_WAIT && state_d == ST_MD_WAIT) begin
                done_q <= done_q | i_md_done;
            end else begin
                done_q <= 1'b0;
            end

            // Counter holds at its limit so a done captured under a long
            // stall is not mistaken for a fresh wait after wrap-around.
            if (cnt_clr) begin
                cnt_q <= '0;
            end else if (state_q == ST_MD_WAIT && cnt_q != CNT_MAX) begin
                cnt_q <= cnt_q + CNT_W'(1);
            end

            if (to_set) begin
                to_q <= 1'b1;
            end
        end
    end

`ifdef PIPE_CTRL_PERF_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            o_perf_stall_cnt <= '0;
            o_perf_flush_cnt <= '0;
        end else begin
            if (go_q && !o_if_en && (o_perf_stall_cnt != {PERF_W{1'b1}})) begin
                o_perf_stall_cnt <= o_perf_stall_cnt + PERF_W'(1);
            end
            if (o_if_id_flush && (o_perf_flush_cnt != {PERF_W{1'b1}})) begin
                o_perf_flush_cnt <= o_perf_flush_cnt + PERF_W'(1);
            end
        end
    end
`endif

endmodule

// File: tb/tb_pipeline_ctrl.sv
// tb/tb_pipeline_ctrl.sv - scoreboard bench for pipeline_ctrl

module tb_pipeline_ctrl;

    // Expected vector layout:
    // {md_start, if_en, id_en, ex_en, if_id_flush, id_ex_bubble, pc_sel, md_timeout, state[1:0]}
    localparam logic [9:0] ALL0     = 10'b0000000000;
    localparam logic [9:0] RUN_ALL  = 10'b0111000000;
    localparam logic [9:0] FLUSH    = 10'b0111111000;
    localparam logic [9:0] MD_START = 10'b1000000000;
    localparam logic [9:0] HZ       = 10'b0001010000;
    localparam logic [9:0] LS_ALL   = 10'b0111000001;
    localparam logic [9:0] LS_STALL = 10'b0000000001;
    localparam logic [9:0] MDW0     = 10'b0000000010;
    localparam logic [9:0] MDW_GO   = 10'b0111000010;
    localparam logic [9:0] TO       = 10'b0000000100;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       ext_stall, uses1, uses2, ex_mem_rd, ex_flush, ex_muldiv, md_done;
    logic [4:0] id_rs1, id_rs2, ex_rd;

    logic       a_start, a_if, a_id, a_ex, a_fl, a_bub, a_pc, a_to;
    logic [1:0] a_st;
    logic       b_start, b_if, b_id, b_ex, b_fl, b_bub, b_pc, b_to;
    logic [1:0] b_st;

    logic [9:0] v0, v1;
    assign v0 = {a_start, a_if, a_id, a_ex, a_fl, a_bub, a_pc, a_to, a_st};
    assign v1 = {b_start, b_if, b_id, b_ex, b_fl, b_bub, b_pc, b_to, b_st};

    always #5 clk = ~clk;

    pipeline_ctrl dut (
        .clk(clk), .rst_n(rst_n), .i_ext_stall(ext_stall),
        .i_id_rs1(id_rs1), .i_id_rs2(id_rs2),
        .i_id_uses_rs1(uses1), .i_id_uses_rs2(uses2),
        .i_ex_mem_rd(ex_mem_rd), .i_ex_rd(ex_rd), .i_ex_flush(ex_flush),
        .i_ex_muldiv(ex_muldiv), .i_md_done(md_done),
        .o_md_start(a_start), .o_if_en(a_if), .o_id_en(a_id), .o_ex_en(a_ex),
        .o_if_id_flush(a_fl), .o_id_ex_bubble(a_bub), .o_pc_sel(a_pc),
        .o_md_timeout(a_to), .o_state(a_st)
    );

    pipeline_ctrl #(.MD_TIMEOUT(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .i_ext_stall(ext_stall),
        .i_id_rs1(id_rs1), .i_id_rs2(id_rs2),
        .i_id_uses_rs1(uses1), .i_id_uses_rs2(uses2),
        .i_ex_mem_rd(ex_mem_rd), .i_ex_rd(ex_rd), .i_ex_flush(ex_flush),
        .i_ex_muldiv(ex_muldiv), .i_md_done(md_done),
        .o_md_start(b_start), .o_if_en(b_if), .o_id_en(b_id), .o_ex_en(b_ex),
        .o_if_id_flush(b_fl), .o_id_ex_bubble(b_bub), .o_pc_sel(b_pc),
        .o_md_timeout(b_to), .o_state(b_st)
    );

    typedef struct {
        logic [9:0] exp;
        bit         sel;
        string      name;
    } exp_t;

    exp_t q[$];
    int   n_cmp = 0;
    int   n_err = 0;

    task automatic push(input logic [9:0] exp, input bit sel, input string name);
        exp_t e;
        e.exp  = exp;
        e.sel  = sel;
        e.name = name;
        q.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clr();
        ext_stall = 1'b0; uses1 = 1'b0; uses2 = 1'b0; ex_mem_rd = 1'b0;
        ex_flush = 1'b0; ex_muldiv = 1'b0; md_done = 1'b0;
        id_rs1 = 5'd0; id_rs2 = 5'd0; ex_rd = 5'd0;
    endtask

    // Monitor: compares every expectation queued for the current cycle.
    always @(negedge clk) begin
        while (q.size() > 0) begin
            exp_t       e;
            logic [9:0] act;
            e   = q.pop_front();
            act = e.sel ? v1 : v0;
            n_cmp++;
            if (act !== e.exp) begin
                n_err++;
                $display("FAIL %s: got %b expected %b", e.name, act, e.exp);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0;
        clr();
        ex_flush = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        push(ALL0, 1'b0, "rst_gate_a");
        push(ALL0, 1'b1, "rst_gate_b");
        tick();
        rst_n = 1'b1;
        ex_flush = 1'b0;
        push(ALL0, 1'b0, "first_cycle_after_rst");
        tick();
        push(RUN_ALL, 1'b0, "run_idle");
        tick();

        // Load-use on rs2, one bubble
        ex_mem_rd = 1'b1; ex_rd = 5'd5; id_rs2 = 5'd5; uses2 = 1'b1;
        push(HZ, 1'b0, "lu_stall");
        tick();
        ex_mem_rd = 1'b0;
        push(LS_ALL, 1'b0, "lu_release");
        tick();
        clr();
        push(RUN_ALL, 1'b0, "lu_back_run");
        tick();

        // Load-use on rs1 with an external stall during LOAD_STALL
        ex_mem_rd = 1'b1; ex_rd = 5'd7; id_rs1 = 5'd7; uses1 = 1'b1;
        push(HZ, 1'b0, "lu_rs1_stall");
        tick();
        ext_stall = 1'b1;
        push(LS_STALL, 1'b0, "ls_ext_stall");
        tick();
        ext_stall = 1'b0;
        push(LS_ALL, 1'b0, "ls_no_recheck");
        tick();
        clr();
        push(RUN_ALL, 1'b0, "ls_back_run");
        tick();

        // x0 destination and unused sources never stall
        ex_mem_rd = 1'b1; ex_rd = 5'd0; id_rs1 = 5'd0; id_rs2 = 5'd0; uses1 = 1'b1; uses2 = 1'b1;
        push(RUN_ALL, 1'b0, "lu_x0");
        tick();
        ex_rd = 5'd9; id_rs1 = 5'd9; uses1 = 1'b0; id_rs2 = 5'd3;
        push(RUN_ALL, 1'b0, "lu_unused_src");
        tick();

        // Flush wins over hazard and mul/div; external stall wins over flush
        uses1 = 1'b1; ex_flush = 1'b1;
        push(FLUSH, 1'b0, "flush_with_hz");
        tick();
        ex_mem_rd = 1'b0; uses1 = 1'b0; ex_muldiv = 1'b1;
        push(FLUSH, 1'b0, "flush_with_md");
        tick();
        ext_stall = 1'b1;
        push(ALL0, 1'b0, "ext_stall_over_flush");
        tick();
        clr();
        push(RUN_ALL, 1'b0, "run_after_flush");
        tick();

        // Mul/div with done 10 cycles after start
        ex_muldiv = 1'b1;
        push(MD_START, 1'b0, "md_start");
        tick();
        for (int i = 1; i <= 9; i++) begin
            ex_flush  = (i == 4);
            ex_mem_rd = (i == 6);
            ex_rd     = 5'd4; id_rs1 = 5'd4; uses1 = 1'b1;
            push(MDW0, 1'b0, "md_wait");
            tick();
        end
        ex_flush = 1'b0; ex_mem_rd = 1'b0; uses1 = 1'b0;
        md_done = 1'b1;
        push(MDW_GO, 1'b0, "md_done_adv");
        tick();
        clr();
        push(RUN_ALL, 1'b0, "md_back_run");
        tick();

        // Done arrives under an external stall and is held until it drops
        ex_muldiv = 1'b1;
        push(MD_START, 1'b0, "md2_start");
        tick();
        push(MDW0, 1'b0, "md2_wait");
        tick();
        md_done = 1'b1; ext_stall = 1'b1;
        push(MDW0, 1'b0, "md2_done_stalled");
        tick();
        md_done = 1'b0;
        for (int i = 0; i < 3; i++) begin
            push(MDW0, 1'b0, "md2_held");
            tick();
        end
        ext_stall = 1'b0;
        push(MDW_GO, 1'b0, "md2_adv");
        tick();
        clr();
        push(RUN_ALL, 1'b0, "md2_run");
        tick();

        // Timeout on the MD_TIMEOUT=8 instance
        rst_n = 1'b0;
        push(ALL0, 1'b1, "rst_b_before_to");
        push(ALL0, 1'b0, "rst_a_before_to");
        tick();
        rst_n = 1'b1;
        push(ALL0, 1'b1, "post_rst_b");
        tick();
        ex_muldiv = 1'b1;
        push(MD_START, 1'b1, "to_start");
        tick();
        for (int i = 1; i <= 7; i++) begin
            push(MDW0, 1'b1, "to_wait");
            tick();
        end
        push(MDW_GO, 1'b1, "to_abort");
        push(MDW0, 1'b0, "main_no_abort");
        tick();
        ex_muldiv = 1'b0;
        push(RUN_ALL | TO, 1'b1, "to_sticky");
        push(MDW0, 1'b0, "main_still_wait");
        tick();
        push(RUN_ALL | TO, 1'b1, "to_sticky2");
        tick();

        // Reset aborts MD_WAIT on the main instance and clears the sticky flag
        rst_n = 1'b0;
        push(ALL0, 1'b0, "rst_mid_mdwait");
        push(ALL0, 1'b1, "rst_clears_to");
        tick();
        rst_n = 1'b1;
        tick();
        push(RUN_ALL, 1'b0, "abort_to_run");
        push(RUN_ALL, 1'b1, "flag_cleared");
        tick();

        repeat (3) tick();
        n_cmp++;
        if (q.size() != 0) begin
            n_err++;
            $display("FAIL scoreboard_drain: got %0d left expected 0", q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/pipeline_ctrl.md
# pipeline_ctrl

Pipeline sequencing controller for the 5-stage RISC-V core. It generates the per-stage clock enables (`clk_en`) and the bubble/flush controls around the execution stage. It detects load-use hazards, freezes the front end while an iterative mul/div unit occupies EX, and applies branch/jump redirects from EX. It sits beside the IF/ID/EX stage registers and drives their enable and squash inputs.

## Interface
Parameters:
- MD_TIMEOUT, 64: maximum cycles to wait for `i_md_done` before an abort.
- PERF_W, 32: performance counter width (only with PIPE_CTRL_PERF_EN).

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- i_ext_stall  in  1  data-memory not ready; freezes the whole pipe.
- i_id_rs1, i_id_rs2  in  5 each  source registers of the instruction in ID.
- i_id_uses_rs1, i_id_uses_rs2  in  1 each  the ID instruction reads rs1/rs2.
- i_ex_mem_rd  in  1  the instruction in EX is a load.
- i_ex_rd  in  5  destination register of the instruction in EX.
- i_ex_flush  in  1  taken branch/jump flag from the EX branch unit.
- i_ex_muldiv  in  1  the instruction in EX is a multi-cycle mul/div.
- i_md_done  in  1  single-cycle pulse: mul/div result valid.
- o_md_start  out  1  single-cycle pulse that launches mul/div.
- o_if_en, o_id_en, o_ex_en  out  1 each  stage register clock enables.
- o_if_id_flush  out  1  squash the IF/ID register contents.
- o_id_ex_bubble  out  1  load a NOP into the ID/EX register.
- o_pc_sel  out  1  1 selects the EX jump address as the next PC.
- o_md_timeout  out  1  sticky error: mul/div did not finish.
- o_state  out  2  current FSM state (debug).

## Operation
- FSM states: RUN=0, LOAD_STALL=1, MD_WAIT=2. Encoding 3 is unused and decodes to RUN.
- Outputs are combinational from the state and the inputs. The state, the done flag, the timeout counter and the error flag are registered.
- Load-use hazard (`hz`) = i_ex_mem_rd && i_ex_rd≠0 && ((i_id_uses_rs1 && i_id_rs1==i_ex_rd) || (i_id_uses_rs2 && i_id_rs2==i_ex_rd)).
- RUN evaluates these conditions in priority order; the first one that matches applies:
  1. i_ext_stall: all enables 0, no flush, no start; stay in RUN.
  2. i_ex_flush: all enables 1, o_pc_sel=1, o_if_id_flush=1, o_id_ex_bubble=1; stay in RUN. A simultaneous i_ex_muldiv or hz is ignored.
  3. i_ex_muldiv: all enables 0, o_md_start=1; go to MD_WAIT and clear the timeout counter.
  4. hz: o_if_en=0, o_id_en=0, o_ex_en=1, o_id_ex_bubble=1; go to LOAD_STALL.
  5. Otherwise: all enables 1, all other outputs 0.
- LOAD_STALL:
  - Normally all enables 1, with no hazard check, then return to RUN.
  - If i_ext_stall, all enables 0 and stay in LOAD_STALL.
- MD_WAIT:
  - Enables are 0 by default. i_ex_flush and hz are ignored.
  - A done flag is set by i_md_done and cleared on leaving the state.
  - When (i_md_done || done flag) && !i_ext_stall: all enables 1, go to RUN.
  - The timeout counter increments each cycle in MD_WAIT, including stalled cycles. When it reaches MD_TIMEOUT-1 without done: set o_md_timeout, all enables 1, go to RUN.
  - o_md_start is never asserted in MD_WAIT.
- o_md_timeout is cleared only by reset.

## Timing
- While rst_n=0 and after reset: state=RUN, done flag=0, timeout counter=0, o_md_timeout=0, perf counters=0.
- While rst_n=0, all o_*_en=0 and o_md_start, o_if_id_flush, o_id_ex_bubble and o_pc_sel are all 0. Combinational outputs resume on the first edge after deassertion.
- Flush: zero-cycle response. The redirect and squash take effect on the same clock edge.
- Load-use stall: exactly 1 bubble cycle.
- Mul/div: the start pulse is issued in the RUN cycle. If done arrives N cycles after start, the EX advance occurs on edge N; with i_ext_stall it occurs on the first unstalled cycle.
- Asserting rst_n mid-MD_WAIT aborts to RUN without a timeout flag. The external mul/div unit is reset by the same rst_n.

## Configuration
- PIPE_CTRL_PERF_EN defined adds output ports o_perf_stall_cnt [PERF_W] and o_perf_flush_cnt [PERF_W].
  - o_perf_stall_cnt increments on every post-reset cycle with o_if_en=0.
  - o_perf_flush_cnt increments on every cycle with o_if_id_flush=1.
  - Both counters saturate at all-ones.
- PIPE_CTRL_PERF_EN undefined: the ports and counters are absent and the remaining behaviour is identical.

## Test plan
- Load-use: i_ex_mem_rd=1, i_ex_rd=5, i_id_rs2=5, uses_rs2=1 → one cycle with if/id_en=0, ex_en=1, bubble=1, state=1, then RUN with all enables 1.
- Load-use with i_ex_rd=0 (x0) → no stall, all enables 1.
- Flush with simultaneous hz=1 → pc_sel=1, if_id_flush=1, bubble=1, all enables 1, state remains 0.
- Mul/div, done 10 cycles after start → single start pulse, enables 0 for 10 cycles, then EX advances, state=0. With PERF_EN, stall_cnt=10.
- Mul/div with done arriving while i_ext_stall=1 for 3 more cycles → enables stay 0 until the stall drops, then advance. Done is not lost.
- Mul/div with MD_TIMEOUT=8 and no done → after 8 cycles o_md_timeout=1 (sticky), enables 1, RUN. A reset clears the flag.
